// File: rtl/ram_lsu_pkg.sv
// Shared encodings and lane helpers for the RV32I load/store controller.
// Sub-word stores are built by read-modify-write because the RAM has no byte enables.
package ram_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StMerge,
    StWr,
    StRsp
  } lsu_state_e;

  // Alignment only; the illegal size code is flagged separately by the caller.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r;
    case (size)
      SZ_HALF: r = addr_lo[0];
      SZ_WORD: r = (addr_lo != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lsu_extract(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'h0});
    case (size)
      SZ_BYTE: r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lsu_merge(input logic [31:0] word, input logic [31:0] wdata,
                                            input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: r[{lane[1], 4'h0} +: 16]   = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_512x32.sv
// Single-port 512x32 RAM with synchronous, read-first output register.
// Contents are deliberately not reset.
module Ram_512x32 (
  input  logic        clk,
  input  logic [8:0]  addr,
  input  logic [31:0] din,
  input  logic        write_en,
  output logic [31:0] dout
);

  logic [31:0] mem [512];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/ram_lsu_ctrl_lane.sv
// Combinational lane logic: load alignment/extension and sub-word store merge.
module lsu_lane_unit
  import ram_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  always_comb begin
    rdata  = lsu_extract(word, size, lane, is_unsigned);
    merged = lsu_merge(word, wdata, size, lane);
  end

endmodule

// File: rtl/ram_lsu_ctrl.sv
// Sequences RV32I loads/stores onto a single-port word RAM, one request at a time.
// Sub-word stores read the word, merge the lane, and write it back.
module ram_lsu_ctrl
  import ram_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_write_en,
  input  logic [31:0]       ram_dout
);

  lsu_state_e        state_q, state_d;
  logic              we_q, uns_q, err_q;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;

  logic        accept, req_err;
  logic [31:0] load_data, merge_data;

  assign req_ready = rst_n & (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign req_err   = (req_size == SZ_ILL) | lsu_misaligned(req_size, req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err)                            state_d = StRsp;
          else if (req_we && req_size == SZ_WORD) state_d = StWr;
          else                                    state_d = StRd;
        end
      end
      StRd:    state_d = we_q ? StMerge : StRsp;
      StMerge: state_d = StRsp;
      StWr:    state_d = StRsp;
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  lsu_lane_unit u_lane (
    .word        (ram_dout),
    .wdata       (wdata_q),
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (uns_q),
    .rdata       (load_data),
    .merged      (merge_data)
  );

  // Gating with rst_n keeps a reset edge from ever committing a write.
  assign ram_write_en = rst_n & ((state_q == StWr) | (state_q == StMerge));

  always_comb begin
    ram_addr  = '0;
    ram_din   = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    unique case (state_q)
      StRd: begin
        ram_addr = addr_q[ADDR_W+1:2];
      end
      StMerge: begin
        ram_addr = addr_q[ADDR_W+1:2];
        ram_din  = merge_data;
      end
      StWr: begin
        ram_addr = addr_q[ADDR_W+1:2];
        ram_din  = wdata_q;
      end
      StRsp: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || we_q) ? 32'h0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_lsu_ctrl.sv
// Self-checking bench for ram_lsu_ctrl with the real RAM; a byte-array memory model
// supplies all expected load data, error flags and latencies.
module tb_ram_lsu_ctrl;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din, ram_dout;
  logic              ram_write_en;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_cnt  = 0;
  int wide_cnt = 0;
  logic rsp_prev = 1'b0;

  logic [7:0] ref_bytes [2048];

  always #5 clk = ~clk;

  ram_lsu_ctrl #(.ADDR_W(ADDR_W)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_write_en (ram_write_en),
    .ram_dout     (ram_dout)
  );

  Ram_512x32 u_ram (
    .clk      (clk),
    .addr     (ram_addr),
    .din      (ram_din),
    .write_en (ram_write_en),
    .dout     (ram_dout)
  );

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (rsp_valid && rsp_prev) wide_cnt++;
    rsp_prev = rsp_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic [10:0] a, input logic [1:0] size);
    return (size == 2'd3) || ((a % nbytes(size)) != 0);
  endfunction

  function automatic void model_store(input logic [10:0] a, input logic [1:0] size,
                                      input logic [31:0] wdata);
    for (int i = 0; i < nbytes(size); i++) ref_bytes[a + 11'(i)] = wdata[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [10:0] a, input logic [1:0] size,
                                             input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    int          v;
    b = ref_bytes[a];
    h = {ref_bytes[a + 11'd1], ref_bytes[a]};
    if (size == 2'd0) begin
      v = $signed(b);
      return uns ? {24'h0, b} : v;
    end else if (size == 2'd1) begin
      v = $signed(h);
      return uns ? {16'h0, h} : v;
    end
    return {ref_bytes[a + 11'd3], ref_bytes[a + 11'd2], h};
  endfunction

  function automatic logic [31:0] model_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  // Issues one request and waits for its response; lat counts cycles after acceptance.
  task automatic do_req(input logic we, input logic [10:0] a, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int wpulses, output int wcycle);
    int budget;
    bit done;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    budget = 0;
    while (!req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; wpulses = 0; wcycle = 0; rdata = 32'h0; err = 1'b0; done = 1'b0;
    while (!done && lat <= 10) begin
      if (ram_write_en) begin
        wpulses++;
        wcycle = lat;
      end
      if (rsp_valid) begin
        rdata = rsp_rdata;
        err   = rsp_err;
        done  = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (ram_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en: got %b want 0", ram_write_en); end
    n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
    n_checks++; if (ram_din !== 32'h0) begin n_fail++; $display("FAIL reset_ram_din: got %h want 0", ram_din); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat, wp, wc;
    do_req(1'b1, 11'h7FC, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, lat, wp, wc);
    model_store(11'h7FC, 2'd2, 32'hDEADBEEF);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_checks++; if (wp !== 1) begin n_fail++; $display("FAIL sw_write_pulses: got %0d want 1", wp); end
    n_checks++; if (u_ram.mem[511] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_ram_word: got %h want deadbeef", u_ram.mem[511]); end
    do_req(1'b0, 11'h7FC, 2'd2, 1'b0, 32'h0, rd, er, lat, wp, wc);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", lat); end
    n_checks++; if (er !== 1'b0 || wp !== 0) begin n_fail++; $display("FAIL lw_err_wr: got err=%b wr=%0d want 0/0", er, wp); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat, wp, wc;
    do_req(1'b1, 11'h7FD, 2'd0, 1'b0, 32'h00000080, rd, er, lat, wp, wc);
    model_store(11'h7FD, 2'd0, 32'h80);
    n_checks++; if (u_ram.mem[511] !== 32'hDEAD80EF) begin n_fail++; $display("FAIL sb_ram_word: got %h want dead80ef", u_ram.mem[511]); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", lat); end
    n_checks++; if (wp !== 1 || wc !== 2) begin n_fail++; $display("FAIL sb_merge_write: got pulses=%0d at=%0d want 1 at 2", wp, wc); end
    do_req(1'b0, 11'h7FD, 2'd0, 1'b0, 32'h0, rd, er, lat, wp, wc);
    n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", rd); end
    do_req(1'b0, 11'h7FD, 2'd0, 1'b1, 32'h0, rd, er, lat, wp, wc);
    n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat, wp, wc;
    do_req(1'b1, 11'h7FE, 2'd1, 1'b0, 32'h00001234, rd, er, lat, wp, wc);
    model_store(11'h7FE, 2'd1, 32'h1234);
    n_checks++; if (u_ram.mem[511] !== 32'h123480EF) begin n_fail++; $display("FAIL sh_ram_word: got %h want 123480ef", u_ram.mem[511]); end
    do_req(1'b0, 11'h7FE, 2'd1, 1'b0, 32'h0, rd, er, lat, wp, wc);
    n_checks++; if (rd !== 32'h00001234) begin n_fail++; $display("FAIL lh_data: got %h want 00001234", rd); end
  endtask

  task automatic test_errors();
    logic        t_we   [3] = '{1'b0, 1'b1, 1'b0};
    logic [10:0] t_addr [3] = '{11'h001, 11'h002, 11'h000};
    logic [1:0]  t_size [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] rd; logic er; int lat, wp, wc;
    for (int i = 0; i < 3; i++) begin
      do_req(t_we[i], t_addr[i], t_size[i], 1'b0, 32'hA5A5A5A5, rd, er, lat, wp, wc);
      n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err%0d_flag: got %b want 1", i, er); end
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err%0d_rdata: got %h want 0", i, rd); end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL err%0d_latency: got %0d want 1", i, lat); end
      n_checks++; if (wp !== 0) begin n_fail++; $display("FAIL err%0d_writes: got %0d want 0", i, wp); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int lat, wp, wc, base, budget;
    do_req(1'b1, 11'h7F0, 2'd2, 1'b0, 32'h00000002, rd, er, lat, wp, wc);
    model_store(11'h7F0, 2'd2, 32'h2);
    @(negedge clk);
    base = rsp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h7F0; req_size = 2'd0; req_wdata = 32'hFF;
    budget = 0;
    while (!req_ready && budget < 20) begin @(negedge clk); budget++; end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (ram_write_en !== 1'b0) begin n_fail++; $display("FAIL abort_write_gate: got %b want 0", ram_write_en); end
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_err, rsp_rdata, ram_write_en, ram_addr, ram_din} !== '0)
      begin n_fail++; $display("FAIL abort_outputs: got %b/%b/%h/%b/%h/%h want all 0", rsp_valid, rsp_err, rsp_rdata, ram_write_en, ram_addr, ram_din); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    n_checks++; if (rsp_cnt !== base) begin n_fail++; $display("FAIL abort_no_rsp: got %0d pulses want 0", rsp_cnt - base); end
    n_checks++; if (u_ram.mem[508] !== model_word(508)) begin n_fail++; $display("FAIL abort_ram_word: got %h want %h", u_ram.mem[508], model_word(508)); end
    do_req(1'b0, 11'h7F0, 2'd2, 1'b0, 32'h0, rd, er, lat, wp, wc);
    n_checks++; if (rd !== 32'h00000002) begin n_fail++; $display("FAIL abort_reload: got %h want 00000002", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    int          acc [$];
    logic [31:0] exp_q [$];
    logic        ld_q [$];
    logic [31:0] e;
    logic        ld;
    int idx, nrsp, wide0;
    for (int k = 0; k < 3; k++) d[k] = $urandom;
    idx = 0; nrsp = 0; wide0 = wide_cnt;
    @(negedge clk);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (idx < 6) begin
        req_valid = 1'b1; req_we = (idx % 2 == 0); req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 11'(32'h20 + 4 * (idx / 2)); req_wdata = d[idx/2];
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        nrsp++;
        if (ld_q.size() > 0) begin
          ld = ld_q.pop_front(); e = exp_q.pop_front();
          n_checks++; if (rsp_rdata !== (ld ? e : 32'h0)) begin n_fail++; $display("FAIL b2b_rdata: got %h want %h", rsp_rdata, ld ? e : 32'h0); end
        end
      end
      if (idx < 6 && req_valid && req_ready) begin
        acc.push_back(cyc);
        ld_q.push_back(idx % 2 == 1);
        exp_q.push_back(d[idx/2]);
        if (idx % 2 == 0) model_store(req_addr, 2'd2, d[idx/2]);
        idx++;
      end
      @(negedge clk);
    end
    n_checks++; if (acc.size() !== 6) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 6", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      n_checks++; if (acc[i] - acc[i-1] !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 3", acc[i] - acc[i-1]); end
    end
    n_checks++; if (nrsp !== 6) begin n_fail++; $display("FAIL b2b_responses: got %0d want 6", nrsp); end
    n_checks++; if (wide_cnt !== wide0) begin n_fail++; $display("FAIL b2b_pulse_width: got %0d wide pulses want 0", wide_cnt - wide0); end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp; logic er, we, uns, xerr; logic [10:0] a; logic [1:0] sz;
    int lat, wp, wc, xlat;
    for (int w = 0; w < 8; w++) begin
      wd = $urandom;
      do_req(1'b1, 11'(4 * w), 2'd2, 1'b0, wd, rd, er, lat, wp, wc);
      model_store(11'(4 * w), 2'd2, wd);
    end
    for (int n = 0; n < 60; n++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = 11'($urandom_range(0, 31));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      xerr = model_err(a, sz);
      xlat = xerr ? 1 : (we && sz != 2'd2) ? 3 : 2;
      exp  = (xerr || we) ? 32'h0 : model_load(a, sz, uns);
      do_req(we, a, sz, uns, wd, rd, er, lat, wp, wc);
      if (!xerr && we) model_store(a, sz, wd);
      n_checks++; if (er !== xerr) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b", n, er, xerr); end
      n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", n, rd, exp); end
      n_checks++; if (lat !== xlat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, xlat); end
      n_checks++; if (wp !== ((we && !xerr) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_writes: got %0d want %0d", n, wp, (we && !xerr) ? 1 : 0); end
    end
    for (int w = 0; w < 8; w++) begin
      n_checks++; if (u_ram.mem[w] !== model_word(w)) begin n_fail++; $display("FAIL rnd_ram_word%0d: got %h want %h", w, u_ram.mem[w], model_word(w)); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_lsu_ctrl.md
# ram_lsu_ctrl

Load/store controller that sequences every RV32I data access (LB/LH/LW/LBU/LHU/SB/SH/SW) onto the single-port 512x32 word RAM. It sits between the core's memory stage and `Ram_512x32`, and handles three jobs:
- converting byte addresses to word addresses;
- aligning loads and sign- or zero-extending them;
- performing read-modify-write for sub-word stores, because the RAM has no byte enables.

Misaligned or illegal requests are rejected without touching the RAM.

## Interface
Parameters
- `ADDR_W`, 9: RAM word-address width; the byte address is `ADDR_W+2` bits.

Ports
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle, request accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in `ADDR_W+2`: byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU); ignored for word accesses and stores.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned or illegal size; valid with `rsp_valid`.
- `ram_addr` out `ADDR_W`: to RAM `addr`.
- `ram_din` out 32: to RAM `din`.
- `ram_write_en` out 1: to RAM `write_en`.
- `ram_dout` in 32: from RAM `dout`. Synchronous read: `dout` is updated at the edge that samples `addr`.

## Operation
- FSM states: IDLE, RD, MERGE, WR, RSP.
- Request latch: on acceptance, `we`, `addr`, `size`, `unsigned` and `wdata` are captured into registers. The FSM uses only the latched copies afterwards.
- State transitions from IDLE on acceptance:
  - Error → RSP. An error is size 11, or half with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - Load → RD.
  - Word store → WR.
  - Byte or half store → RD.
- Other transitions:
  - RD → RSP for a load; RD → MERGE for a sub-word store.
  - MERGE → RSP.
  - WR → RSP.
  - RSP → IDLE, unconditionally.
- `ram_addr`: equals latched `addr[ADDR_W+1:2]` in RD, MERGE and WR; 0 otherwise.
- `ram_write_en`: equals `rst_n & (state==WR | state==MERGE)`, so a write never occurs on a reset edge.
- `ram_din`:
  - WR: latched `wdata`.
  - MERGE: `ram_dout` with the addressed lane replaced, using little-endian lanes.
    - Byte: lane `addr[1:0]` gets `wdata[7:0]`.
    - Half: `addr[1]` selects bits `[15:0]` or `[31:16]`, which get `wdata[15:0]`.
  - Otherwise: 0.
- Load extraction in RSP, combinational from `ram_dout`:
  - Byte: `ram_dout` shifted right by 8·`addr[1:0]`, low 8 bits kept, then sign- or zero-extended.
  - Half: shifted right by 16·`addr[1]`, low 16 bits kept, then extended.
  - Word: passed through.
- `rsp_err`: equals 1 in RSP when the latched request was flagged as an error. `rsp_rdata` is 0 in that case.
- Error requests: never assert `ram_write_en` and never drive a nonzero `ram_addr`.

## Timing
- Acceptance edge is E0; `req_ready` is 1 exactly in IDLE while `rst_n=1`.
- Load: RD during E0–E1, RSP during E1–E2. `rsp_valid` is high in the cycle after E1, so latency is 2 cycles and throughput is 1 load per 3 cycles.
- Word store: RAM write at E1; `rsp_valid` in the cycle after E1.
- Sub-word store: RAM read at E1, merged write at E2; `rsp_valid` in the cycle after E2.
- Error: `rsp_valid` and `rsp_err` in the cycle after E0.
- No back-to-back acceptance: a new request is taken only at the edge ending an IDLE cycle, so a request held across RSP waits one cycle.
- Reset values (state IDLE): `rsp_valid`, `rsp_err`, `rsp_rdata`, `ram_write_en`, `ram_addr` and `ram_din` are 0; `req_ready` is 1 from the first cycle after reset release.
- Reset mid-operation: the sequence is aborted and no response is produced. An aborted RMW leaves the RAM word unchanged.
- RAM contents are not cleared by reset.

## Structure
- Package `ram_lsu_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the FSM state encoding;
  - functions `lsu_misaligned(size, addr_lo)`, `lsu_extract(word, size, lane, unsigned)` and `lsu_merge(word, wdata, size, lane)`.
- One combinational sub-module, `lsu_lane_unit`, wraps the extract and merge logic.
- The FSM, request latch and RAM drive stay in `ram_lsu_ctrl`.
- Bench instantiates `ram_lsu_ctrl` together with the real `Ram_512x32`.

## Test plan
- SW to byte address 0x7FC with wdata 0xDEADBEEF, then LW from 0x7FC → RAM word 511 = 0xDEADBEEF; LW `rsp_rdata`=0xDEADBEEF; `rsp_valid` 2 cycles after acceptance.
- SB of 0x80 to 0x7FD, then LB 0x7FD and LBU 0x7FD:
  - word 511 becomes 0xDEAD80EF;
  - LB returns 0xFFFFFF80;
  - LBU returns 0x00000080;
  - `ram_write_en` high only in the MERGE cycle.
- SH of 0x1234 to 0x7FE, then LH 0x7FE → word 0x123480EF; LH returns 0x00001234.
- LH at 0x001, SW at 0x002, and a request with size 11 → each gives `rsp_err`=1 and `rsp_rdata`=0 one cycle after acceptance, with zero `ram_write_en` pulses.
- `rst_n` driven low during the MERGE cycle of an SB to 0x7F0 with word 508 preloaded to 0x00000002 → word 508 stays 0x00000002; no `rsp_valid`; all outputs 0; `req_ready`=1 the cycle after release.
- Hold `req_valid` continuously with alternating LW/SW → exactly one acceptance per 3 cycles; each `rsp_valid` pulse is exactly one cycle wide.
